// File: rtl/pixel_unpacker_if.sv
// rtl/pixel_unpacker_if.sv - 32-bit packed-pixel stream carrying tuser/tlast framing.
interface pixel_unpacker_if;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast;
    logic        tuser;
    logic        tvalid;
    logic        tready;

    modport master (output tdata, output tkeep, output tlast, output tuser, output tvalid, input tready);
    modport slave  (input tdata, input tkeep, input tlast, input tuser, input tvalid, output tready);
endinterface

// File: rtl/pixel_unpacker.sv
// rtl/pixel_unpacker.sv - unpacks 3 stream words into 4 RGB888 pixels with x/y and framing checks.
// Optional keep_err/frame_count statistics under PIXEL_UNPACKER_STATS_EN.
module pixel_unpacker #(
    parameter int X_SIZE = 640,
    parameter int Y_SIZE = 480
) (
    input  logic              aclk,
    input  logic              areset,
    pixel_unpacker_if.slave   in_stream,
    output logic [7:0]        r,
    output logic [7:0]        g,
    output logic [7:0]        b,
    output logic [9:0]        x,
    output logic [8:0]        y,
    output logic              sof,
    output logic              eol,
    output logic              pix_valid,
    input  logic              pix_ready,
    input  logic              clear_err,
    output logic              sof_err,
    output logic              eol_err,
    output logic              keep_err,
    output logic [15:0]       frame_count
);
    localparam logic [9:0] XMAX = 10'(X_SIZE - 1);
    localparam logic [9:0] XPEN = 10'(X_SIZE - 2);
    localparam logic [8:0] YMAX = 9'(Y_SIZE - 1);

    typedef enum logic [1:0] {PH0, PH1, PH2, PH3} phase_t;

    phase_t      phase;
    logic [9:0]  pos_x;
    logic [8:0]  pos_y;
    logic [23:0] residue;
    logic        brk;

    logic        adv, hs, sof_hit, last_exp, last_bad, early;
    phase_t      eff_phase, nxt_phase;
    logic [9:0]  eff_x;
    logic [8:0]  eff_y;
    logic [23:0] pix_word, nres;

    function automatic logic [9:0] inc_x(input logic [9:0] cx);
        return (cx == XMAX) ? 10'd0 : cx + 10'd1;
    endfunction

    function automatic logic [8:0] inc_line(input logic [8:0] cy);
        return (cy == YMAX) ? 9'd0 : cy + 9'd1;
    endfunction

    function automatic logic [8:0] inc_y(input logic [9:0] cx, input logic [8:0] cy);
        return (cx == XMAX) ? inc_line(cy) : cy;
    endfunction

    assign adv              = !pix_valid || pix_ready;
    assign in_stream.tready = adv && (phase != PH3);
    assign hs               = in_stream.tvalid && in_stream.tready;

    // An off-position tuser restarts the frame before the tlast check is made.
    always_comb begin
        sof_hit   = in_stream.tuser && !(phase == PH0 && pos_x == 10'd0 && pos_y == 9'd0);
        eff_phase = sof_hit ? PH0 : phase;
        eff_x     = sof_hit ? 10'd0 : pos_x;
        eff_y     = sof_hit ? 9'd0 : pos_y;
        last_exp  = (eff_phase == PH2) && (eff_x == XPEN);
        last_bad  = in_stream.tlast != last_exp;
        early     = in_stream.tlast && !last_exp;
        pix_word  = in_stream.tdata[23:0];
        nres      = {16'h0, in_stream.tdata[31:24]};
        nxt_phase = PH1;
        case (eff_phase)
            PH0: begin
                pix_word  = in_stream.tdata[23:0];
                nres      = {16'h0, in_stream.tdata[31:24]};
                nxt_phase = PH1;
            end
            PH1: begin
                pix_word  = {in_stream.tdata[15:0], residue[7:0]};
                nres      = {8'h0, in_stream.tdata[31:16]};
                nxt_phase = PH2;
            end
            default: begin
                pix_word  = {in_stream.tdata[7:0], residue[15:0]};
                nres      = in_stream.tdata[31:8];
                nxt_phase = PH3;
            end
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            phase     <= PH0;
            pos_x     <= 10'd0;
            pos_y     <= 9'd0;
            residue   <= 24'd0;
            brk       <= 1'b0;
            pix_valid <= 1'b0;
            r         <= 8'd0;
            g         <= 8'd0;
            b         <= 8'd0;
            x         <= 10'd0;
            y         <= 9'd0;
            sof       <= 1'b0;
            eol       <= 1'b0;
            sof_err   <= 1'b0;
            eol_err   <= 1'b0;
        end else begin
            if (adv) begin
                if (hs) begin
                    {r, g, b} <= pix_word;
                    x         <= eff_x;
                    y         <= eff_y;
                    sof       <= (eff_x == 10'd0) && (eff_y == 9'd0);
                    eol       <= eff_x == XMAX;
                    pix_valid <= 1'b1;
                    if (early && eff_phase != PH2) begin
                        phase   <= PH0;
                        pos_x   <= 10'd0;
                        pos_y   <= inc_line(eff_y);
                        residue <= 24'd0;
                        brk     <= 1'b0;
                    end else begin
                        // A stray tlast on W2 still lets p3 out before the line break.
                        phase   <= nxt_phase;
                        pos_x   <= inc_x(eff_x);
                        pos_y   <= inc_y(eff_x, eff_y);
                        residue <= nres;
                        brk     <= early;
                    end
                end else if (phase == PH3) begin
                    {r, g, b} <= residue;
                    x         <= pos_x;
                    y         <= pos_y;
                    sof       <= (pos_x == 10'd0) && (pos_y == 9'd0);
                    eol       <= pos_x == XMAX;
                    pix_valid <= 1'b1;
                    phase     <= PH0;
                    residue   <= 24'd0;
                    brk       <= 1'b0;
                    pos_x     <= brk ? 10'd0 : inc_x(pos_x);
                    pos_y     <= brk ? inc_line(pos_y) : inc_y(pos_x, pos_y);
                end else begin
                    pix_valid <= 1'b0;
                end
            end

            if (hs && sof_hit)
                sof_err <= 1'b1;
            else if (clear_err)
                sof_err <= 1'b0;

            if (hs && last_bad)
                eol_err <= 1'b1;
            else if (clear_err)
                eol_err <= 1'b0;
        end
    end

`ifdef PIXEL_UNPACKER_STATS_EN
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            keep_err    <= 1'b0;
            frame_count <= 16'd0;
        end else begin
            if (hs && in_stream.tkeep != 4'hF)
                keep_err <= 1'b1;
            else if (clear_err)
                keep_err <= 1'b0;

            if (pix_valid && pix_ready && x == XMAX && y == YMAX)
                frame_count <= frame_count + 16'd1;
        end
    end
`else
    logic unused_keep;
    assign unused_keep = ^in_stream.tkeep;
    assign keep_err    = 1'b0;
    assign frame_count = 16'd0;
`endif
endmodule

// File: doc/pixel_unpacker.md
Name: pixel_unpacker

Overview:
- Sink end of the 32-bit packed-pixel video stream that the pixel generator drives.
- Accepts the AXI-Stream words and unpacks each group of 3 words into 4 RGB888 pixels.
- Presents one pixel per handshake, with x/y position, start-of-frame (sof) and end-of-line (eol) markers.
- Checks tuser/tlast framing against X_SIZE/Y_SIZE and resynchronises on errors. Used in loopback verification and as the front end of on-chip frame consumers.

Parameters:
- X_SIZE, 640, pixels per line; must be a multiple of 4.
- Y_SIZE, 480, lines per frame.

Ports:
- aclk  in  1  single clock for all logic.
- areset  in  1  asynchronous reset, active-high.
- in_stream_tdata  in  32  packed pixel word.
- in_stream_tkeep  in  4  byte enables; ignored unless the optional feature is enabled.
- in_stream_tlast  in  1  last word of a line.
- in_stream_tuser  in  1  first word of a frame.
- in_stream_tvalid  in  1  word valid.
- in_stream_tready  out  1  word accepted when high with tvalid.
- r, g, b  out  8 each  pixel colour.
- x  out  10  pixel column, 0..X_SIZE-1.
- y  out  9  pixel row, 0..Y_SIZE-1.
- sof  out  1  high with the pixel at x=0, y=0.
- eol  out  1  high with the pixel at x=X_SIZE-1.
- pix_valid  out  1  pixel outputs valid.
- pix_ready  in  1  downstream accepts the pixel.
- clear_err  in  1  one-cycle pulse; clears the sticky error flags.
- sof_err  out  1  sticky: tuser seen off-position.
- eol_err  out  1  sticky: tlast missing or misplaced.
- keep_err  out  1  sticky tkeep error (optional feature).
- frame_count  out  16  completed frames (optional feature).

Behaviour:
- Packing format (pixel p = {r,g,b}, 24 bits):
  - W0 = {p1[7:0], p0[23:0]}
  - W1 = {p2[15:0], p1[23:8]}
  - W2 = {p3[23:0], p2[23:16]}
- Phase state machine, PH0 -> PH1 -> PH2 -> PH3 -> PH0:
  - PH0 consumes W0, emits p0, keeps an 8-bit residue.
  - PH1 consumes W1, emits p1, keeps a 16-bit residue.
  - PH2 consumes W2, emits p2, keeps a 24-bit residue.
  - PH3 consumes no word and emits p3 from the residue.
- Output register:
  - Advance condition adv = !pix_valid || pix_ready.
  - in_stream_tready = adv && phase != PH3 (combinational).
  - A pixel appears on outputs the cycle after its word handshake: 1-cycle latency.
  - PH3 pixel loads on the next adv cycle after PH2.
  - Outputs hold stable while pix_valid && !pix_ready.
- Full-rate throughput: 4 pixels per 3 accepted words; tready low 1 cycle in 4 when pix_ready is held high.
- x/y counters:
  - Position register holds x/y of the next pixel to load.
  - x wraps at X_SIZE-1 to 0 with y+1; y wraps at Y_SIZE-1 to 0.
  - sof = (x==0 && y==0) and eol = (x==X_SIZE-1), both registered with the pixel.
- tuser expected on W0 at x=0, y=0.
  - tuser on any other accepted word: set sof_err, then treat that word as W0 of a new frame (phase PH0, x=0, y=0, pixel emitted as p0 with sof=1).
  - Missing tuser at expected position: not an error; counting continues.
- tlast expected exactly on the W2 whose p2 has x=X_SIZE-2.
  - Missing tlast there: set eol_err, continue counting.
  - tlast on any other word: set eol_err, emit the pixels that word completes, discard the residue, then force PH0, x=0, y=y+1 (wrapping).
- Simultaneous tuser and tlast on one word: tuser handling applies first, tlast check follows for the new position.
- Error flags:
  - Set on the handshake cycle.
  - clear_err clears them; a set in the same cycle wins over clear.
- Reset (asynchronous, any time including mid-frame):
  - phase=PH0, x=0, y=0, residue=0, pix_valid=0.
  - r=g=b=0, sof=0, eol=0, all error flags 0, frame_count=0.
  - in_stream_tready=1 after release.
  - A partially received group is discarded.

Optional Feature:
- Macro PIXEL_UNPACKER_STATS_EN.
- Defined:
  - keep_err sets on any accepted word with tkeep != 4'hF; the word is still processed.
  - frame_count increments (wrapping at 16 bits) when the pixel with x=X_SIZE-1, y=Y_SIZE-1 completes its pix_valid && pix_ready handshake.
- Undefined:
  - keep_err and frame_count are tied to 0; tkeep is unused.

Test Plan:
- Group unpack:
  - Stimulus: W0=32'h44332211, W1=32'h88776655, W2=32'hCCBBAA99 with pix_ready=1.
  - Required: p0=24'h332211, p1=24'h665544, p2=24'h998877, p3=24'hCCBBAA.
  - Required: tready low exactly 1 cycle after W2.
- Full frame 640x480:
  - Stimulus: correct tuser/tlast, pix_ready=1.
  - Required: 307200 pixels; sof once; eol 480 times at x=639; no errors; frame_count=1 when STATS_EN is defined.
- Backpressure:
  - Stimulus: pix_ready toggling 1-of-3 cycles.
  - Required: no pixel lost or duplicated; outputs stable while stalled; tready=0 whenever the output is full and stalled.
- Early tlast:
  - Stimulus: tlast on the W1 of the group at x=100.
  - Required: eol_err=1; next pixel x=0, y=1; clear_err returns eol_err to 0.
- Spurious tuser:
  - Stimulus: tuser on the word at x=320, y=5.
  - Required: sof_err=1; that pixel sof=1, x=0, y=0.
- Reset mid-line:
  - Stimulus: areset after W1.
  - Required: pix_valid=0 immediately; next W0 produces p0 at x=0, y=0.
